// File: rtl/frame_receiver.sv
// Video sink: measures line width and frame height, counts frames and checks that pixel
// data forms a continuous +1 sequence across the whole stream.
module frame_receiver (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN_I,
  input  logic        H_SYNC,
  input  logic        V_SYNC,
  input  logic        EN,
  input  logic [9:0]  DATA,
  input  logic [10:0] EXP_W,
  input  logic [10:0] EXP_H,
  output logic [10:0] MEAS_W,
  output logic [10:0] MEAS_H,
  output logic [31:0] FRAME_CNT,
  output logic        FRAME_DONE,
  output logic        ERR_DATA,
  output logic        ERR_GEOM,
  output logic [15:0] ERR_CNT,
  output logic        LOCKED
);

  typedef enum logic [1:0] {StSeek = 2'd0, StWaitV = 2'd1, StActive = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [10:0] x_q, x_d, y_q, y_d, meas_w_q, meas_w_d, meas_h_q, meas_h_d;
  logic [9:0]  exp_data_q, exp_data_d;
  logic        seeded_q, seeded_d, hs_q, short_q, short_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;
  logic        frame_done_q, frame_done_d, err_data_q, err_data_d;
  logic        err_geom_q, err_geom_d, locked_q, locked_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  logic        in_frame, width_term, bad;
  logic [10:0] x_base, y_base, y_fin;
  logic        short_base, short_fin;

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    short_d      = short_q;
    exp_data_d   = exp_data_q;
    seeded_d     = seeded_q;
    meas_w_d     = meas_w_q;
    meas_h_d     = meas_h_q;
    frame_cnt_d  = frame_cnt_q;
    frame_done_d = 1'b0;
    err_data_d   = err_data_q;
    err_geom_d   = err_geom_q;
    err_cnt_d    = err_cnt_q;
    locked_d     = locked_q;
    width_term   = 1'b0;
    bad          = 1'b0;
    y_fin        = y_q;
    short_fin    = short_q;

    // Geometry counters restart from zero when a frame opens out of WAIT_V.
    x_base     = (state_q == StWaitV) ? 11'd0 : x_q;
    y_base     = (state_q == StWaitV) ? 11'd0 : y_q;
    short_base = (state_q == StWaitV) ? 1'b0 : short_q;
    in_frame   = !V_SYNC && (state_q == StWaitV || state_q == StActive);

    unique case (state_q)
      StSeek: if (V_SYNC) state_d = StWaitV;
      StWaitV: begin
        x_d     = 11'd0;
        y_d     = 11'd0;
        short_d = 1'b0;
        if (!V_SYNC) state_d = StActive;
      end
      StActive: begin
        if (V_SYNC) begin
          // A partial line pending at frame end counts as a short line.
          if (x_q != 11'd0) begin
            meas_w_d = x_q;
            y_fin    = sat_inc(y_q);
            if (EXP_W != 11'd0) short_fin = 1'b1;
          end
          bad          = ((EXP_H != 11'd0) && (y_fin != EXP_H)) || short_fin;
          meas_h_d     = y_fin;
          locked_d     = !bad;
          if (bad) err_geom_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 32'd1;
          frame_done_d = 1'b1;
          x_d          = 11'd0;
          y_d          = 11'd0;
          short_d      = 1'b0;
          state_d      = StWaitV;
        end
      end
      default: state_d = StSeek;
    endcase

    if (in_frame) begin
      x_d     = x_base;
      y_d     = y_base;
      short_d = short_base;
      if (EN) begin
        if (seeded_q && (DATA != exp_data_q)) begin
          err_data_d = 1'b1;
          if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        end
        seeded_d   = 1'b1;
        exp_data_d = DATA + 10'd1;
        if ((EXP_W != 11'd0) && (({1'b0, x_base} + 12'd1) == {1'b0, EXP_W})) begin
          width_term = 1'b1;
          meas_w_d   = EXP_W;
          x_d        = 11'd0;
          y_d        = sat_inc(y_base);
        end else begin
          x_d = sat_inc(x_base);
        end
      end
      // Width termination wins over a coincident H_SYNC rise.
      if (!width_term && !hs_q && H_SYNC && (x_d != 11'd0)) begin
        meas_w_d = x_d;
        y_d      = sat_inc(y_d);
        x_d      = 11'd0;
        if (EXP_W != 11'd0) begin
          short_d    = 1'b1;
          err_geom_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= StSeek;
      x_q          <= 11'd0;
      y_q          <= 11'd0;
      short_q      <= 1'b0;
      exp_data_q   <= 10'd0;
      seeded_q     <= 1'b0;
      hs_q         <= 1'b1;
      meas_w_q     <= 11'd0;
      meas_h_q     <= 11'd0;
      frame_cnt_q  <= 32'd0;
      frame_done_q <= 1'b0;
      err_data_q   <= 1'b0;
      err_geom_q   <= 1'b0;
      err_cnt_q    <= 16'd0;
      locked_q     <= 1'b0;
    end else if (EN_I) begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      short_q      <= short_d;
      exp_data_q   <= exp_data_d;
      seeded_q     <= seeded_d;
      hs_q         <= H_SYNC;
      meas_w_q     <= meas_w_d;
      meas_h_q     <= meas_h_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
      err_data_q   <= err_data_d;
      err_geom_q   <= err_geom_d;
      err_cnt_q    <= err_cnt_d;
      locked_q     <= locked_d;
    end
  end

  assign MEAS_W     = meas_w_q;
  assign MEAS_H     = meas_h_q;
  assign FRAME_CNT  = frame_cnt_q;
  assign FRAME_DONE = frame_done_q;
  assign ERR_DATA   = err_data_q;
  assign ERR_GEOM   = err_geom_q;
  assign ERR_CNT    = err_cnt_q;
  assign LOCKED     = locked_q;

endmodule
